mem_probe_clear: RTL and testbench

- Parametrised successor to the menu core's hard-wired SDRAM size probe and background RAM-clear loop.
- Writes NPROBE signatures to power-of-two aliasing addresses, reads them back and reports a presence mask of which address bits decode.
- Then, optionally, sweeps a zero-fill across a configurable range so that later cores start with clean RAM.
- Sits between the core's control logic and a single-word SDRAM/DDR controller that uses a ready/strobe handshake.

---
 rtl/mem_probe_clear.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_probe_clear.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_probe_clear.sv
// Memory size probe followed by an optional throttled zero-fill, driving a
// single-word memory controller through a ready/strobe handshake.
module mem_probe_clear #(
    parameter int AW         = 27,
    parameter int DW         = 16,
    parameter int NPROBE     = 3,
    parameter int SIG_SEED   = 1032,
    parameter int SIG_STEP   = 1032,
    parameter int GUARD_DATA = 12345,
    parameter int CLEAR_EN   = 1,
    parameter int CLR_AW     = 25,
    parameter int CLR_GAP    = 31
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [DW-1:0]     mem_dout,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    output logic [NPROBE-1:0] probe_mask,
    output logic              probe_done,
    output logic              clear_done,
    output logic              busy
);

    localparam int IW = $clog2(NPROBE);
    localparam int CW = CLR_AW + 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NPROBE - 1);
    localparam logic [AW-1:0] GUARD_ADDR = AW'(1) << (AW - NPROBE);
    localparam logic [7:0]    GAP_LAST   = 8'(CLR_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_GUARD,
        S_RD,
        S_CLEAR,
        S_DONE
    } state_e;

    // ISSUE: strobe on ready; GAP: mandatory dead cycle; WAIT: read data
    // capture on ready; THROT: clear bandwidth throttle.
    typedef enum logic [1:0] {
        P_ISSUE,
        P_GAP,
        P_WAIT,
        P_THROT
    } phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;
    logic [NPROBE-1:0] mask_q, mask_d;
    logic              pdone_q, pdone_d;
    logic              cdone_q, cdone_d;
    logic              started_q, started_d;
    logic              issue;
    logic              go_wr;

    function automatic logic [AW-1:0] probe_addr(input logic [IW-1:0] i);
        if (i == '0) begin
            return '0;
        end
        return AW'(1) << (AW - NPROBE + int'(i));
    endfunction

    function automatic logic [DW-1:0] sig_of(input logic [IW-1:0] i);
        return DW'(SIG_SEED) + DW'(i) * DW'(SIG_STEP);
    endfunction

    assign issue      = (phase_q == P_ISSUE) && mem_ready;
    assign mem_we     = issue && (state_q inside {S_WR, S_GUARD, S_CLEAR});
    assign mem_rd     = issue && (state_q == S_RD);
    assign busy       = !(state_q inside {S_IDLE, S_DONE});
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign probe_mask = mask_q;
    assign probe_done = pdone_q;
    assign clear_done = cdone_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= P_ISSUE;
            idx_q     <= '0;
            clr_cnt_q <= '0;
            gap_cnt_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            mask_q    <= '0;
            pdone_q   <= 1'b0;
            cdone_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            clr_cnt_q <= clr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            mask_q    <= mask_d;
            pdone_q   <= pdone_d;
            cdone_q   <= cdone_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        clr_cnt_d = clr_cnt_q;
        gap_cnt_d = gap_cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        mask_d    = mask_q;
        pdone_d   = pdone_q;
        cdone_d   = cdone_q;
        started_d = started_q;
        go_wr     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start || (!started_q && mem_ready)) begin
                    go_wr = 1'b1;
                end
            end

            // Highest probe first so a low alias overwrites a high one.
            S_WR: begin
                if (phase_q == P_ISSUE) begin
                    if (mem_ready) begin
                        phase_d = P_GAP;
                    end
                end else if (idx_q == '0) begin
                    state_d = S_GUARD;
                    phase_d = P_ISSUE;
                    addr_d  = GUARD_ADDR;
                    din_d   = DW'(GUARD_DATA);
                end else begin
                    phase_d = P_ISSUE;
                    idx_d   = idx_q - 1'b1;
                    addr_d  = probe_addr(idx_q - 1'b1);
                    din_d   = sig_of(idx_q - 1'b1);
                end
            end

            S_GUARD: begin
                if (phase_q == P_ISSUE) begin
                    if (mem_ready) begin
                        phase_d = P_GAP;
                    end
                end else begin
                    state_d = S_RD;
                    phase_d = P_ISSUE;
                    idx_d   = LAST_IDX;
                    addr_d  = probe_addr(LAST_IDX);
                    din_d   = '0;
                end
            end

            S_RD: begin
                unique case (phase_q)
                    P_ISSUE: begin
                        if (mem_ready) begin
                            phase_d = P_GAP;
                        end
                    end
                    P_GAP: phase_d = P_WAIT;
                    default: begin
                        if (mem_ready) begin
                            mask_d[idx_q] = (mem_dout == sig_of(idx_q));
                            phase_d       = P_ISSUE;
                            if (idx_q == '0) begin
                                pdone_d = 1'b1;
                                if (CLEAR_EN != 0) begin
                                    state_d   = S_CLEAR;
                                    clr_cnt_d = '0;
                                    addr_d    = '0;
                                    din_d     = '0;
                                end else begin
                                    state_d = S_DONE;
                                    cdone_d = 1'b1;
                                end
                            end else begin
                                idx_d  = idx_q - 1'b1;
                                addr_d = probe_addr(idx_q - 1'b1);
                            end
                        end
                    end
                endcase
            end

            // Terminal detect on the counter carry keeps the last address
            // on the bus instead of wrapping back to zero.
            S_CLEAR: begin
                unique case (phase_q)
                    P_ISSUE: begin
                        if (mem_ready) begin
                            clr_cnt_d = clr_cnt_q + 1'b1;
                            phase_d   = P_GAP;
                        end
                    end
                    P_GAP: begin
                        if (clr_cnt_q[CLR_AW]) begin
                            state_d = S_DONE;
                            phase_d = P_ISSUE;
                            cdone_d = 1'b1;
                        end else if (CLR_GAP == 0) begin
                            phase_d = P_ISSUE;
                            addr_d  = AW'(clr_cnt_q[CLR_AW-1:0]);
                        end else begin
                            phase_d   = P_THROT;
                            gap_cnt_d = '0;
                        end
                    end
                    default: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            phase_d = P_ISSUE;
                            addr_d  = AW'(clr_cnt_q[CLR_AW-1:0]);
                        end else begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                endcase
            end

            default: begin
                if (start) begin
                    go_wr = 1'b1;
                end
            end
        endcase

        if (go_wr) begin
            state_d   = S_WR;
            phase_d   = P_ISSUE;
            idx_d     = LAST_IDX;
            addr_d    = probe_addr(LAST_IDX);
            din_d     = sig_of(LAST_IDX);
            mask_d    = '0;
            pdone_d   = 1'b0;
            cdone_d   = 1'b0;
            started_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_probe_clear.sv
// Scoreboard bench for mem_probe_clear: a controller model with optional
// address aliasing and ready stretching, plus an expected-event queue.
module tb_mem_probe_clear;

    logic        clk_sys;
    logic        reset_n;
    logic        start;
    logic        mem_ready;
    logic [15:0] mem_dout;
    logic [26:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_rd;
    logic [2:0]  probe_mask;
    logic        probe_done;
    logic        clear_done;
    logic        busy;

    typedef struct {
        int          kind;
        logic [26:0] addr;
        logic [15:0] data;
        bit          isClr;
    } exp_t;

    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleCnt = 0;
    int          readyDelay = 0;
    int          lowCnt = 0;
    bit          readyEnable = 0;
    bit          aliasMode = 0;
    bit          readPending = 0;
    int          sampleCycle = 0;
    int          lastClr = 0;
    logic        pdPrev = 0;
    logic        cdPrev = 0;
    logic [15:0] memArr [logic [26:0]];

    mem_probe_clear #(
        .CLR_AW  (4),
        .CLR_GAP (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start      (start),
        .mem_ready  (mem_ready),
        .mem_dout   (mem_dout),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .probe_mask (probe_mask),
        .probe_done (probe_done),
        .clear_done (clear_done),
        .busy       (busy)
    );

    initial clk_sys = 0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cycleCnt++;

    function automatic logic [15:0] sig(int i);
        return 16'(1032 + i * 1032);
    endfunction

    function automatic logic [26:0] probeAddr(int i);
        logic [26:0] one;
        one = 27'd1;
        return (i == 0) ? 27'd0 : (one << (24 + i));
    endfunction

    function automatic logic [26:0] effAddr(logic [26:0] a);
        return aliasMode ? (a & ~27'h4000000) : a;
    endfunction

    // Controller model: ready drops for readyDelay cycles after each strobe.
    assign mem_ready = readyEnable && (lowCnt == 0);

    initial mem_dout = '0;
    always @(posedge clk_sys) begin
        if (mem_we) memArr[effAddr(mem_addr)] = mem_din;
        if (mem_rd) mem_dout <= memArr.exists(effAddr(mem_addr)) ? memArr[effAddr(mem_addr)] : 16'd0;
        if (mem_we || mem_rd) lowCnt <= readyDelay;
        else if (lowCnt > 0) lowCnt <= lowCnt - 1;
    end

    // Monitor: probe/clear completion is handled before strobes so that the
    // first clear write, which shares a cycle with probe_done, pops in order.
    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset_n) begin
            pdPrev = 0;
            cdPrev = 0;
            readPending = 0;
        end else begin
            if (probe_done && !pdPrev) begin
                vectors++;
                if (expQ.size() == 0 || expQ[0].kind != 2) begin
                    miscompares++;
                    $display("[TB] FAIL probe_done: unexpected rise at cycle %0d", cycleCnt);
                end else begin
                    e = expQ.pop_front();
                    if (probe_mask != e.data[2:0]) begin
                        miscompares++;
                        $display("[TB] FAIL probe_mask: got %b expected %b", probe_mask, e.data[2:0]);
                    end
                    vectors++;
                    if (cycleCnt != sampleCycle + 1) begin
                        miscompares++;
                        $display("[TB] FAIL probe_done timing: got cycle %0d expected %0d", cycleCnt, sampleCycle + 1);
                    end
                end
            end
            if (clear_done && !cdPrev) begin
                vectors++;
                if (expQ.size() == 0 || expQ[0].kind != 3) begin
                    miscompares++;
                    $display("[TB] FAIL clear_done: unexpected rise at cycle %0d", cycleCnt);
                end else begin
                    e = expQ.pop_front();
                    if (mem_addr != e.addr) begin
                        miscompares++;
                        $display("[TB] FAIL clear end addr: got %h expected %h", mem_addr, e.addr);
                    end
                end
            end
            if (mem_we || mem_rd) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL strobe: unexpected we=%b rd=%b addr=%h", mem_we, mem_rd, mem_addr);
                end else begin
                    e = expQ.pop_front();
                    if ((mem_we && mem_rd) || !mem_ready || e.kind != (mem_we ? 0 : 1) ||
                        mem_addr != e.addr || (mem_we && mem_din != e.data)) begin
                        miscompares++;
                        $display("[TB] FAIL strobe: got we=%b rd=%b rdy=%b addr=%h din=%0d expected kind=%0d addr=%h din=%0d",
                                 mem_we, mem_rd, mem_ready, mem_addr, mem_din, e.kind, e.addr, e.data);
                    end
                    if (e.isClr && e.addr != 0) begin
                        vectors++;
                        if (cycleCnt - lastClr < 4) begin
                            miscompares++;
                            $display("[TB] FAIL clear spacing: got %0d cycles expected >= 4", cycleCnt - lastClr);
                        end
                    end
                    if (e.isClr) lastClr = cycleCnt;
                end
                if (mem_rd) begin
                    readPending = 1;
                    sampleCycle = cycleCnt + 1000000;
                    lastClr = cycleCnt;
                end
                if (mem_rd) sampleCycle = cycleCnt;
            end else if (readPending && mem_ready && cycleCnt >= sampleCycle + 2) begin
                sampleCycle = cycleCnt;
                readPending = 0;
            end
            pdPrev = probe_done;
            cdPrev = clear_done;
        end
    end

    task automatic pushExp(int kind, logic [26:0] addr, logic [15:0] data, bit isClr);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.isClr = isClr;
        expQ.push_back(e);
    endtask

    task automatic expectRun(logic [2:0] mask);
        for (int i = 2; i >= 0; i--) pushExp(0, probeAddr(i), sig(i), 0);
        pushExp(0, 27'h1000000, 16'd12345, 0);
        for (int i = 2; i >= 0; i--) pushExp(1, probeAddr(i), 16'd0, 0);
        pushExp(2, 27'd0, {13'd0, mask}, 0);
        for (int a = 0; a < 16; a++) pushExp(0, 27'(a), 16'd0, 1);
        pushExp(3, 27'd15, 16'd0, 0);
    endtask

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(string tag);
        checkOutput({tag, " mem_we"}, 64'(mem_we), 0);
        checkOutput({tag, " mem_rd"}, 64'(mem_rd), 0);
        checkOutput({tag, " mem_addr"}, 64'(mem_addr), 0);
        checkOutput({tag, " mem_din"}, 64'(mem_din), 0);
        checkOutput({tag, " probe_mask"}, 64'(probe_mask), 0);
        checkOutput({tag, " probe_done"}, 64'(probe_done), 0);
        checkOutput({tag, " clear_done"}, 64'(clear_done), 0);
        checkOutput({tag, " busy"}, 64'(busy), 0);
    endtask

    task automatic applyStimulus();
        @(negedge clk_sys);
        start = 1;
        @(negedge clk_sys);
        start = 0;
    endtask

    task automatic waitDrain(string name, int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s drain: got %0d events left expected 0", name, expQ.size());
            expQ.delete();
        end
        repeat (10) @(negedge clk_sys);
        #1;
        checkOutput({name, " idle busy"}, 64'(busy), 0);
    endtask

    initial begin
        int n;
        start = 0;
        reset_n = 1;
        #2 reset_n = 0;
        repeat (3) @(negedge clk_sys);
        checkAllZero("reset");

        expectRun(3'b111);
        reset_n = 1;
        repeat (3) @(negedge clk_sys);
        checkOutput("no start without ready", 64'(busy), 0);
        readyEnable = 1;
        waitDrain("auto run", 3000);

        // Restart from DONE, with a stray start pulse during readback.
        expectRun(3'b111);
        applyStimulus();
        #1;
        checkOutput("restart probe_done", 64'(probe_done), 0);
        checkOutput("restart clear_done", 64'(clear_done), 0);
        checkOutput("restart mask", 64'(probe_mask), 0);
        checkOutput("restart busy", 64'(busy), 1);
        n = 0;
        while (!mem_rd && n < 500) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        checkOutput("reached readback", 64'(mem_rd), 1);
        #1 start = 1;
        @(negedge clk_sys);
        start = 0;
        waitDrain("restart run", 3000);

        aliasMode = 1;
        expectRun(3'b011);
        applyStimulus();
        waitDrain("alias run", 3000);
        aliasMode = 0;

        readyDelay = 7;
        expectRun(3'b111);
        applyStimulus();
        waitDrain("slow ready run", 6000);
        readyDelay = 0;

        // Reset while the addr-5 clear write is on the bus.
        expectRun(3'b111);
        applyStimulus();
        n = 0;
        while (!(mem_we && mem_addr == 27'd5 && probe_done) && n < 1000) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        checkOutput("reached clear addr 5", 64'(mem_we && mem_addr == 27'd5), 1);
        #1 reset_n = 0;
        #1;
        checkAllZero("async reset");
        expQ.delete();
        expectRun(3'b111);
        repeat (3) @(negedge clk_sys);
        reset_n = 1;
        waitDrain("post reset run", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
